// File: rtl/rs232_pkg.sv
// rs232_pkg: byte width and frame FSM state encoding shared by the RS-232 receive blocks and benches.
package rs232_pkg;
    localparam int RS232_BYTE_W = 8;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ADDR = 3'd1,
        WAIT_DATA = 3'd2,
        WAIT_SUM  = 3'd3,
        DONE      = 3'd4,
        ERROR     = 3'd5
    } state_t;
endpackage

// File: rtl/rs232_timeout_cnt.sv
// rs232_timeout_cnt: inter-byte idle counter; expired while the count sits at TIMEOUT_CYCLES-1.
module rs232_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic CLK_50MHZ,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] cnt;
    assign expired = cnt == LAST;
    // saturates at the terminal count so expired stays asserted until cleared
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) cnt <= '0;
        else cnt <= clr ? '0 : (en && !expired) ? cnt + W'(1) : cnt;
    end
endmodule

// File: rtl/rs232_frame_fsm.sv
// rs232_frame_fsm: assembles address + data (+ optional checksum) frames from UART byte strobes
// and issues a one-cycle write strobe or error strobe per frame.
module rs232_frame_fsm
    import rs232_pkg::*;
#(
    parameter int DATA_BYTES     = 1,
    parameter int CHECKSUM_EN    = 0,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                                CLK_50MHZ,
    input  logic                                RST,
    input  logic                                RX_DONE,
    input  logic [RS232_BYTE_W-1:0]             RX_DATA,
    output logic                                WR_EN,
    output logic [RS232_BYTE_W-1:0]             WR_ADDR,
    output logic [RS232_BYTE_W*DATA_BYTES-1:0]  WR_DATA,
    output logic                                ERR,
    output logic                                BUSY,
    output logic [2:0]                          state
);
    localparam int DW = RS232_BYTE_W * DATA_BYTES;
    localparam int CW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);
    state_t st;
    logic [RS232_BYTE_W-1:0] sh_addr, sum;
    logic [DW-1:0] sh_data, nxt_data;
    logic [CW-1:0] cnt;
    logic active, tmo;
    assign state = st;
    assign active = st == WAIT_DATA || st == WAIT_SUM;
    assign nxt_data = (sh_data << RS232_BYTE_W) | DW'(RX_DATA);
    rs232_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .CLK_50MHZ(CLK_50MHZ),
        .RST(RST),
        .clr(RX_DONE || !active),
        .en(active),
        .expired(tmo)
    );
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            st      <= IDLE;
            WR_EN   <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
            sh_addr <= '0;
            sh_data <= '0;
            sum     <= '0;
            cnt     <= '0;
        end else begin
            WR_EN <= 1'b0;
            ERR   <= 1'b0;
            case (st)
                IDLE: st <= WAIT_ADDR;
                WAIT_ADDR: if (RX_DONE) begin
                    sh_addr <= RX_DATA;
                    sum     <= RX_DATA;
                    cnt     <= '0;
                    BUSY    <= 1'b1;
                    st      <= WAIT_DATA;
                end
                // a byte arriving on the terminal count cycle takes priority over the timeout
                WAIT_DATA: if (RX_DONE) begin
                    sh_data <= nxt_data;
                    sum     <= sum + RX_DATA;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        if (CHECKSUM_EN != 0) st <= WAIT_SUM;
                        else begin
                            st      <= DONE;
                            BUSY    <= 1'b0;
                            WR_EN   <= 1'b1;
                            WR_ADDR <= sh_addr;
                            WR_DATA <= nxt_data;
                        end
                    end
                end else if (tmo) begin
                    st   <= ERROR;
                    ERR  <= 1'b1;
                    BUSY <= 1'b0;
                end
                WAIT_SUM: if (RX_DONE) begin
                    BUSY <= 1'b0;
                    if (RX_DATA == sum) begin
                        st      <= DONE;
                        WR_EN   <= 1'b1;
                        WR_ADDR <= sh_addr;
                        WR_DATA <= sh_data;
                    end else begin
                        st  <= ERROR;
                        ERR <= 1'b1;
                    end
                end else if (tmo) begin
                    st   <= ERROR;
                    ERR  <= 1'b1;
                    BUSY <= 1'b0;
                end
                DONE, ERROR: st <= WAIT_ADDR;
                default: begin
                    st   <= IDLE;
                    BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rs232_frame_fsm.sv
// tb_rs232_frame_fsm: directed frames on four parameterisations of the frame FSM.
module tb_rs232_frame_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rxd = '0;
    logic [7:0] rx_data = '0;
    logic [3:0] wr_en, err, busy;
    logic [2:0] st [4];
    logic [7:0] ad [4];
    logic [7:0]  d1, d3;
    logic [15:0] d2;
    logic [31:0] d4;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rs232_frame_fsm #(.DATA_BYTES(1), .CHECKSUM_EN(0)) u1 (
        .CLK_50MHZ(clk), .RST(rst), .RX_DONE(rxd[0]), .RX_DATA(rx_data),
        .WR_EN(wr_en[0]), .WR_ADDR(ad[0]), .WR_DATA(d1), .ERR(err[0]), .BUSY(busy[0]), .state(st[0]));
    rs232_frame_fsm #(.DATA_BYTES(2), .CHECKSUM_EN(1)) u2 (
        .CLK_50MHZ(clk), .RST(rst), .RX_DONE(rxd[1]), .RX_DATA(rx_data),
        .WR_EN(wr_en[1]), .WR_ADDR(ad[1]), .WR_DATA(d2), .ERR(err[1]), .BUSY(busy[1]), .state(st[1]));
    rs232_frame_fsm #(.DATA_BYTES(1), .CHECKSUM_EN(0), .TIMEOUT_CYCLES(20)) u3 (
        .CLK_50MHZ(clk), .RST(rst), .RX_DONE(rxd[2]), .RX_DATA(rx_data),
        .WR_EN(wr_en[2]), .WR_ADDR(ad[2]), .WR_DATA(d3), .ERR(err[2]), .BUSY(busy[2]), .state(st[2]));
    rs232_frame_fsm #(.DATA_BYTES(4), .CHECKSUM_EN(1)) u4 (
        .CLK_50MHZ(clk), .RST(rst), .RX_DONE(rxd[3]), .RX_DATA(rx_data),
        .WR_EN(wr_en[3]), .WR_ADDR(ad[3]), .WR_DATA(d4), .ERR(err[3]), .BUSY(busy[3]), .state(st[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // returns 1 ns after the edge that sampled the strobe
    task automatic send(input int i, input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rxd[i] = 1'b1;
        @(posedge clk); #1;
        rxd[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(st[0]), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(ad[0]), 0);
        chk("rst_data", d4, 0);
        rst = 1'b0;
        tick();
        chk("idle_to_wait_addr", 32'(st[0]), 1);
        chk("idle_to_wait_addr_u4", 32'(st[3]), 1);

        send(0, 8'h12);
        chk("t1_state_wait_data", 32'(st[0]), 2);
        chk("t1_busy", 32'(busy[0]), 1);
        repeat (100) @(posedge clk);
        #1;
        chk("t1_no_early_wr", 32'(wr_en[0]), 0);
        send(0, 8'hAB);
        chk("t1_wr_en", 32'(wr_en[0]), 1);
        chk("t1_addr", 32'(ad[0]), 32'h12);
        chk("t1_data", 32'(d1), 32'hAB);
        chk("t1_err", 32'(err[0]), 0);
        chk("t1_state_done", 32'(st[0]), 4);
        chk("t1_busy_low", 32'(busy[0]), 0);
        tick();
        chk("t1_wr_en_pulse", 32'(wr_en[0]), 0);
        chk("t1_back_wait_addr", 32'(st[0]), 1);
        chk("t1_addr_hold", 32'(ad[0]), 32'h12);

        send(1, 8'h05);
        send(1, 8'h01);
        send(1, 8'h02);
        chk("t2_state_wait_sum", 32'(st[1]), 3);
        chk("t2_busy_sum", 32'(busy[1]), 1);
        send(1, 8'h08);
        chk("t2_wr_en", 32'(wr_en[1]), 1);
        chk("t2_addr", 32'(ad[1]), 32'h05);
        chk("t2_data", 32'(d2), 32'h0102);
        chk("t2_err_none", 32'(err[1]), 0);
        send(1, 8'h05);
        send(1, 8'h01);
        send(1, 8'h02);
        send(1, 8'h09);
        chk("t2_bad_sum_err", 32'(err[1]), 1);
        chk("t2_bad_sum_state", 32'(st[1]), 5);
        chk("t2_bad_sum_no_wr", 32'(wr_en[1]), 0);
        send(1, 8'h06);
        send(1, 8'h03);
        send(1, 8'h04);
        send(1, 8'h00);
        chk("t2_bad_sum2_err", 32'(err[1]), 1);
        chk("t2_addr_kept", 32'(ad[1]), 32'h05);
        chk("t2_data_kept", 32'(d2), 32'h0102);
        tick();
        chk("t2_err_pulse", 32'(err[1]), 0);
        chk("t2_back_wait_addr", 32'(st[1]), 1);

        send(2, 8'h33);
        repeat (19) @(posedge clk);
        #1;
        chk("t3_before_timeout_state", 32'(st[2]), 2);
        chk("t3_before_timeout_err", 32'(err[2]), 0);
        tick();
        chk("t3_timeout_err", 32'(err[2]), 1);
        chk("t3_timeout_state", 32'(st[2]), 5);
        tick();
        chk("t3_after_err_state", 32'(st[2]), 1);
        chk("t3_err_pulse", 32'(err[2]), 0);
        send(2, 8'h44);
        send(2, 8'h55);
        chk("t3_next_wr_en", 32'(wr_en[2]), 1);
        chk("t3_next_addr", 32'(ad[2]), 32'h44);
        chk("t3_next_data", 32'(d3), 32'h55);

        tick();
        send(2, 8'h66);
        repeat (18) @(posedge clk);
        #1;
        send(2, 8'h77);
        chk("t4_terminal_wr_en", 32'(wr_en[2]), 1);
        chk("t4_terminal_no_err", 32'(err[2]), 0);
        chk("t4_terminal_addr", 32'(ad[2]), 32'h66);
        chk("t4_terminal_data", 32'(d3), 32'h77);

        send(3, 8'hFF);
        send(3, 8'hFF);
        send(3, 8'h01);
        send(3, 8'h00);
        send(3, 8'h00);
        send(3, 8'hFF);
        chk("t5_wr_en", 32'(wr_en[3]), 1);
        chk("t5_err_none", 32'(err[3]), 0);
        chk("t5_addr", 32'(ad[3]), 32'hFF);
        chk("t5_data", d4, 32'hFF010000);

        tick();
        send(0, 8'h21);
        chk("t6_mid_frame", 32'(st[0]), 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_state", 32'(st[0]), 0);
        chk("t6_async_busy", 32'(busy[0]), 0);
        chk("t6_async_addr", 32'(ad[0]), 0);
        chk("t6_async_data", 32'(d1), 0);
        chk("t6_async_u4_data", d4, 0);
        #1 rst = 1'b0;
        tick();
        chk("t6_restart", 32'(st[0]), 1);
        send(0, 8'h3C);
        send(0, 8'hC3);
        chk("t6_wr_en", 32'(wr_en[0]), 1);
        chk("t6_addr", 32'(ad[0]), 32'h3C);
        chk("t6_data", 32'(d1), 32'hC3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
